multi_pulse_gen: RTL

- Parametrised successor to the single-shot K1 pulse block.
- Detects rising edges on a trigger input (the TEM comparator line) and fires N_CH independent output pulses, each with its own programmable start delay and width. Covers the K1/K2 relay/drive sequencing on the PCB test board.
- Sits between the test-control register bank (cfg inputs) and the board drive pins.

---
 rtl/multi_pulse_pkg.sv | 27 ++
 rtl/multi_pulse_chan.sv | 111 +++++++++++
 rtl/multi_pulse_gen.sv | 117 +++++++++++
 3 files changed

// File: rtl/multi_pulse_pkg.sv
// -----------------------------------------------------------------------------
// multi_pulse_pkg
// Shared definitions for the multi-channel pulse generator: the per-channel
// state encoding, default parameter values, and a helper that locates a
// channel's field inside the packed configuration buses.
// No ports (package).
// -----------------------------------------------------------------------------
package multi_pulse_pkg;

  // Per-channel sequencing states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_PULSE = 2'd2
  } chan_state_e;

  // Default build: two channels (K1/K2), 32-bit counters, 2 us at 400 MHz
  localparam int unsigned DEF_N_CH        = 2;
  localparam int unsigned DEF_CNT_W       = 32;
  localparam int unsigned DEF_PULSE_WIDTH = 800;

  // LSB of channel 'ch' inside a bus that packs one cnt_w-wide field per channel
  function automatic int unsigned cfg_lsb(input int unsigned ch, input int unsigned cnt_w);
    return ch * cnt_w;
  endfunction

endpackage

// File: rtl/multi_pulse_chan.sv
// -----------------------------------------------------------------------------
// multi_pulse_chan
// One pulse channel: waits a latched delay after a start strobe, then drives
// its output high for a latched width. Delay and width are captured at start
// so configuration changes mid-sequence have no effect.
//
// Ports:
//   clk_i     in   system clock
//   rst_i     in   synchronous active-high reset
//   enable_i  in   global enable; low forces the channel back to idle
//   start_i   in   one-cycle start strobe (already qualified by the top)
//   delay_i   in   start delay in cycles, sampled with start_i
//   width_i   in   effective pulse width in cycles, sampled with start_i
//   pulse_o   out  registered pulse output
//   active_o  out  channel is not idle
// -----------------------------------------------------------------------------
module multi_pulse_chan
  import multi_pulse_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] delay_i,
  input  logic [CNT_W-1:0] width_i,
  output logic             pulse_o,
  output logic             active_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  chan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [CNT_W-1:0] delay_q, delay_d;
  logic [CNT_W-1:0] width_q, width_d;
  logic             pulse_q, pulse_d;

  // State, counter, latched configuration and output register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      delay_q <= '0;
      width_q <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      delay_q <= delay_d;
      width_q <= width_d;
      pulse_q <= pulse_d;
    end
  end

  // Next-state logic. The counter restarts from zero on every state change
  // and the terminal compare ends the state before it could ever wrap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    delay_d = delay_q;
    width_d = width_q;
    if (!enable_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            delay_d = delay_i;
            width_d = width_i;
            cnt_d   = '0;
            if (delay_i != '0) begin
              state_d = ST_DELAY;
            end else if (width_i != '0) begin
              state_d = ST_PULSE;
            end
          end
        end
        ST_DELAY: begin
          if (cnt_q == delay_q - CNT_ONE) begin
            cnt_d   = '0;
            state_d = (width_q != '0) ? ST_PULSE : ST_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_PULSE: begin
          if (cnt_q == width_q - CNT_ONE) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output is registered from the current state, so it trails the state by
  // one cycle; a dropped enable clears it on the very next edge.
  assign pulse_d  = enable_i && (state_q == ST_PULSE);
  assign pulse_o  = pulse_q;
  assign active_o = (state_q != ST_IDLE);

endmodule

// File: rtl/multi_pulse_gen.sv
// -----------------------------------------------------------------------------
// multi_pulse_gen
// Detects rising edges on the TEM trigger line and launches N_CH independent
// delayed pulses (K1 = bit 0, K2 = bit 1, ...). Edges arriving while any
// channel is still running are dropped and flagged on trig_missed_o.
//
// Build option:
//   MULTI_PULSE_TRIG_SYNC_EN  - when defined, trig_i passes through a 2-flop
//                               synchroniser first (adds 2 cycles of latency).
//
// Ports:
//   clk_i          in   system clock
//   rst_i          in   synchronous active-high reset
//   enable_i       in   global enable; low forces all channels idle
//   trig_i         in   trigger input, rising edge starts a sequence
//   cfg_ch_en_i    in   [N_CH]        per-channel enable, sampled at trigger
//   cfg_delay_i    in   [N_CH*CNT_W]  per-channel delay, ch i at [i*CNT_W +: CNT_W]
//   cfg_width_i    in   [N_CH*CNT_W]  per-channel width, same packing
//   cfg_use_def_i  in   substitute DEF_WIDTH for any zero width
//   pulse_out_o    out  [N_CH] channel pulse outputs
//   busy_o         out  registered OR of all channels not idle
//   trig_missed_o  out  one-cycle strobe: an edge arrived while busy
// -----------------------------------------------------------------------------
module multi_pulse_gen
  import multi_pulse_pkg::*;
#(
  parameter int unsigned N_CH      = DEF_N_CH,
  parameter int unsigned CNT_W     = DEF_CNT_W,
  parameter int unsigned DEF_WIDTH = DEF_PULSE_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic                  trig_i,
  input  logic [N_CH-1:0]       cfg_ch_en_i,
  input  logic [N_CH*CNT_W-1:0] cfg_delay_i,
  input  logic [N_CH*CNT_W-1:0] cfg_width_i,
  input  logic                  cfg_use_def_i,
  output logic [N_CH-1:0]       pulse_out_o,
  output logic                  busy_o,
  output logic                  trig_missed_o
);

  logic            trig_src;
  logic            trig_q, trig_qq;
  logic            trig_edge;
  logic            start;
  logic            busy_q, busy_d;
  logic            trig_missed_q, trig_missed_d;
  logic [N_CH-1:0] chan_active;

`ifdef MULTI_PULSE_TRIG_SYNC_EN
  logic sync1_q, sync2_q;

  // Two-flop synchroniser for an asynchronous trigger source
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= trig_i;
      sync2_q <= sync1_q;
    end
  end

  assign trig_src = sync2_q;
`else
  assign trig_src = trig_i;
`endif

  // Edge detect plus the registered busy/missed flags. Because busy is
  // registered, an edge in the cycle the last channel goes idle still sees
  // busy and is dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      trig_q        <= 1'b0;
      trig_qq       <= 1'b0;
      busy_q        <= 1'b0;
      trig_missed_q <= 1'b0;
    end else begin
      trig_q        <= trig_src;
      trig_qq       <= trig_q;
      busy_q        <= busy_d;
      trig_missed_q <= trig_missed_d;
    end
  end

  assign trig_edge     = trig_q & ~trig_qq;
  assign start         = trig_edge & enable_i & ~busy_q;
  assign busy_d        = |chan_active;
  assign trig_missed_d = trig_edge & busy_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    logic [CNT_W-1:0] cfg_w;
    logic [CNT_W-1:0] eff_w;

    assign cfg_w = cfg_width_i[cfg_lsb(i, CNT_W) +: CNT_W];
    assign eff_w = ((cfg_w == '0) && cfg_use_def_i) ? CNT_W'(DEF_WIDTH) : cfg_w;

    multi_pulse_chan #(
      .CNT_W(CNT_W)
    ) u_chan (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .enable_i(enable_i),
      .start_i (start & cfg_ch_en_i[i]),
      .delay_i (cfg_delay_i[cfg_lsb(i, CNT_W) +: CNT_W]),
      .width_i (eff_w),
      .pulse_o (pulse_out_o[i]),
      .active_o(chan_active[i])
    );
  end

  assign busy_o        = busy_q;
  assign trig_missed_o = trig_missed_q;

endmodule
